mem_access_unit: RTL and testbench



---
 rtl/rv32i_types.sv | 14 +
 rtl/load_extend.sv | 30 +++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32/RV64 pipeline types: memory-stage FSM states, access sizes and
// the funct3 encodings that only exist on RV64.
package rv32i_types;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} mem_size_t;

  localparam logic [2:0] load_f3_ld  = 3'b011;
  localparam logic [2:0] load_f3_lwu = 3'b110;
  localparam logic [2:0] store_f3_sd = 3'b011;
  localparam logic [2:0] f3_reserved = 3'b111;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed bytes out of a memory word and sign- or zero-extends
// them to the register width according to the load funct3.
module load_extend #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (funct3)
      3'b000:  ld_data = DATA_W'($signed(shifted[7:0]));
      3'b001:  ld_data = DATA_W'($signed(shifted[15:0]));
      3'b010:  ld_data = DATA_W'($signed(shifted[31:0]));
      3'b100:  ld_data = DATA_W'(shifted[7:0]);
      3'b101:  ld_data = DATA_W'(shifted[15:0]);
      3'b110:  ld_data = DATA_W'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipelined MEM stage: issues one registered load/store to a variable-latency
// data memory, stalls until the response, and returns extended load data.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_rmask,
  output logic [DATA_W/8-1:0] dmem_wmask,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_resp,
  output logic                ld_valid,
  output logic [DATA_W-1:0]   ld_data,
  output logic                misaligned,
  output logic                illegal
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  mem_state_t        state, next_state;
  mem_size_t         size;
  logic              mem_op, f3_illegal, misalign, issue;
  logic [OFF_W-1:0]  offset;
  logic [NB-1:0]     base_mask, byte_mask;
  logic [DATA_W-1:0] wdata_shift, wdata_lane, ext_data;
  logic              op_load;
  logic [2:0]        op_f3;
  logic [OFF_W-1:0]  op_off;

  assign mem_op      = req_valid & (req_load | req_store);
  assign size        = mem_size_t'(req_funct3[1:0]);
  assign offset      = req_addr[OFF_W-1:0];
  assign byte_mask   = base_mask << offset;
  assign wdata_shift = req_wdata << {offset, 3'b000};

  // 011 and 110 are the RV64-only LD/SD and LWU encodings.
  always_comb begin
    f3_illegal = (req_funct3 == f3_reserved);
    if (DATA_W == 32 && (req_funct3 == load_f3_ld || req_funct3 == store_f3_sd ||
                         req_funct3 == load_f3_lwu))
      f3_illegal = 1'b1;
  end

  always_comb begin
    base_mask = '0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE:   base_mask = NB'(1);
      SZ_HALF:   begin base_mask = NB'(3);  misalign = req_addr[0];     end
      SZ_WORD:   begin base_mask = NB'(15); misalign = |req_addr[1:0];  end
      SZ_DOUBLE: begin base_mask = '1;      misalign = |req_addr[2:0];  end
      default:   base_mask = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NB; i++)
      wdata_lane[8*i +: 8] = byte_mask[i] ? wdata_shift[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Faults are reported in IDLE only, since the request is held through WAIT.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (f3_illegal)    illegal    = 1'b1;
          else if (misalign) misaligned = 1'b1;
          else begin
            stall      = 1'b1;
            issue      = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_resp) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst_n) begin
      stall      = 1'b0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      issue      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
      op_load    <= 1'b0;
      op_f3      <= '0;
      op_off     <= '0;
    end else if (issue) begin
      dmem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      dmem_rmask <= req_load  ? byte_mask  : '0;
      dmem_wmask <= req_store ? byte_mask  : '0;
      dmem_wdata <= req_store ? wdata_lane : '0;
      op_load    <= req_load;
      op_f3      <= req_funct3;
      op_off     <= offset;
    end else if (state == WAIT && dmem_resp) begin
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      ld_valid   <= op_load;
      if (op_load) ld_data <= ext_data;
    end else if (state == DONE) begin
      ld_valid <= 1'b0;
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata   (dmem_rdata),
    .offset  (op_off),
    .funct3  (op_f3),
    .ld_data (ext_data)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: an RV32 and an RV64 instance share the
// request bus, and `wide` selects which one is driven and observed.
module tb_mem_access_unit;

  logic        clk, rst_n, wide;
  logic        req_valid, req_load, req_store, resp;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, rdata;

  logic        stall32, ldv32, mis32, ill32;
  logic [31:0] addr32, wdata32, ld32;
  logic [3:0]  rmask32, wmask32;
  logic        stall64, ldv64, mis64, ill64;
  logic [31:0] addr64;
  logic [63:0] wdata64, ld64;
  logic [7:0]  rmask64, wmask64;

  logic        o_stall, o_ldv, o_mis, o_ill;
  logic [31:0] o_addr;
  logic [7:0]  o_rmask, o_wmask;
  logic [63:0] o_wdata, o_ld;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !wide), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .stall(stall32), .dmem_addr(addr32),
    .dmem_rmask(rmask32), .dmem_wmask(wmask32), .dmem_wdata(wdata32),
    .dmem_rdata(rdata[31:0]), .dmem_resp(resp && !wide), .ld_valid(ldv32),
    .ld_data(ld32), .misaligned(mis32), .illegal(ill32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && wide), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall64), .dmem_addr(addr64),
    .dmem_rmask(rmask64), .dmem_wmask(wmask64), .dmem_wdata(wdata64),
    .dmem_rdata(rdata), .dmem_resp(resp && wide), .ld_valid(ldv64),
    .ld_data(ld64), .misaligned(mis64), .illegal(ill64)
  );

  always_comb begin
    o_stall = wide ? stall64 : stall32;
    o_ldv   = wide ? ldv64   : ldv32;
    o_mis   = wide ? mis64   : mis32;
    o_ill   = wide ? ill64   : ill32;
    o_addr  = wide ? addr64  : addr32;
    o_rmask = wide ? rmask64 : {4'b0, rmask32};
    o_wmask = wide ? wmask64 : {4'b0, wmask32};
    o_wdata = wide ? wdata64 : {32'b0, wdata32};
    o_ld    = wide ? ld64    : {32'b0, ld32};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd);
    wide       = w;
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // Full legal access; response arrives in the (delay+1)-th WAIT cycle.
  task automatic mem_access(input string tag, input logic w, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] wd,
                            input logic [63:0] rd, input int delay, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata, input logic [63:0] exp_ld);
    logic [31:0] exp_addr;
    exp_addr = w ? (addr & ~32'd7) : (addr & ~32'd3);
    drive_req(w, ld, st, f3, addr, wd);
    #1;
    check_output({tag, ".stall_c0"}, o_stall, 1);
    check_output({tag, ".fault_c0"}, {o_mis, o_ill}, 0);
    check_output({tag, ".rmask_c0"}, o_rmask, 0);
    if (ld) exp_q.push_back(exp_ld);
    step();
    for (int k = 0; k <= delay; k++) begin
      check_output({tag, ".stall_wait"}, o_stall, 1);
      check_output({tag, ".addr"}, o_addr, exp_addr);
      check_output({tag, ".rmask"}, o_rmask, ld ? exp_mask : 8'h00);
      check_output({tag, ".wmask"}, o_wmask, st ? exp_mask : 8'h00);
      check_output({tag, ".wdata"}, o_wdata, st ? exp_wdata : 64'h0);
      if (k == delay) begin
        resp  = 1'b1;
        rdata = rd;
      end
      step();
    end
    resp = 1'b0;
    check_output({tag, ".stall_done"}, o_stall, 0);
    check_output({tag, ".bus_cleared"}, {o_rmask, o_wmask, o_wdata}, 0);
    check_output({tag, ".ld_valid"}, o_ldv, ld);
    if (o_ldv) begin
      if (exp_q.size() == 0) check_output({tag, ".unexpected_load"}, 1, 0);
      else check_output({tag, ".ld_data"}, o_ld, exp_q.pop_front());
    end
    req_valid = 1'b0;
    step();
    check_output({tag, ".ld_valid_idle"}, o_ldv, 0);
  endtask

  task automatic fault_access(input string tag, input logic w, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic exp_mis, input logic exp_ill);
    drive_req(w, ld, st, f3, addr, 64'h0);
    #1;
    check_output({tag, ".misaligned"}, o_mis, exp_mis);
    check_output({tag, ".illegal"}, o_ill, exp_ill);
    check_output({tag, ".stall"}, o_stall, 0);
    step();
    check_output({tag, ".no_issue"}, {o_rmask, o_wmask, o_stall}, 0);
    req_valid = 1'b0;
    #1;
    check_output({tag, ".flag_drop"}, {o_mis, o_ill}, 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; wide = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; rdata = '0; resp = 1'b0;
    #12;
    check_output("reset32", {o_stall, o_ldv, o_rmask, o_wmask, o_addr}, 0);
    wide = 1'b1;
    #1;
    check_output("reset64", {o_stall, o_ldv, o_rmask, o_wmask, o_ld}, 0);
    rst_n = 1'b1;
    step();

    mem_access("lw",  0, 1, 0, 3'b010, 32'h1000_0004, 64'h0, 64'hDEAD_BEEF, 0, 8'h0F, 64'h0, 64'hDEAD_BEEF);
    mem_access("lb",  0, 1, 0, 3'b000, 32'h1000_0003, 64'h0, 64'h80AB_CDEF, 0, 8'h08, 64'h0, 64'hFFFF_FF80);
    mem_access("lbu", 0, 1, 0, 3'b100, 32'h1000_0003, 64'h0, 64'h80AB_CDEF, 1, 8'h08, 64'h0, 64'h0000_0080);
    mem_access("sh",  0, 0, 1, 3'b001, 32'h2000_0002, 64'h1234_ABCD, 64'h0, 5, 8'h0C, 64'hABCD_0000, 64'h0);
    mem_access("lh",  0, 1, 0, 3'b001, 32'h2000_0002, 64'h0, 64'h9876_0000, 2, 8'h0C, 64'h0, 64'hFFFF_9876);
    mem_access("lhu", 0, 1, 0, 3'b101, 32'h2000_0002, 64'h0, 64'h9876_0000, 0, 8'h0C, 64'h0, 64'h0000_9876);
    mem_access("sb",  0, 0, 1, 3'b000, 32'h2000_0001, 64'hFFFF_FF5A, 64'h0, 0, 8'h02, 64'h0000_5A00, 64'h0);

    fault_access("lh_mis",  0, 1, 0, 3'b001, 32'h1000_0001, 1, 0);
    fault_access("sw_mis",  0, 0, 1, 3'b010, 32'h1000_0006, 1, 0);
    fault_access("ld_rv32", 0, 1, 0, 3'b011, 32'h1000_0000, 0, 1);
    fault_access("f3_111",  0, 1, 0, 3'b111, 32'h1000_0000, 0, 1);

    // ALU-type instruction passing through: no stall, no bus activity.
    drive_req(0, 0, 0, 3'b010, 32'h1000_0000, 64'h0);
    #1;
    check_output("nonmem.stall", o_stall, 0);
    step();
    check_output("nonmem.no_issue", {o_rmask, o_wmask, o_stall}, 0);
    req_valid = 1'b0;
    step();

    mem_access("lwu64", 1, 1, 0, 3'b110, 32'h0000_1004, 64'h0, 64'h8765_4321_0BAD_F00D, 0, 8'hF0, 64'h0, 64'h0000_0000_8765_4321);
    mem_access("lw64",  1, 1, 0, 3'b010, 32'h0000_1004, 64'h0, 64'h8765_4321_0BAD_F00D, 1, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
    mem_access("sd64",  1, 0, 1, 3'b011, 32'h0000_1008, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    mem_access("ld64",  1, 1, 0, 3'b011, 32'h0000_1008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210);
    mem_access("sh64",  1, 0, 1, 3'b001, 32'h0000_100E, 64'h0000_0000_0000_BEEF, 64'h0, 0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);
    fault_access("ld64_mis", 1, 1, 0, 3'b011, 32'h0000_1004, 1, 0);
    fault_access("f3_111_64", 1, 0, 1, 3'b111, 32'h0000_1000, 0, 1);

    // Reset in the middle of WAIT abandons the load; a stray response is ignored.
    drive_req(0, 1, 0, 3'b010, 32'h3000_0008, 64'h0);
    #1;
    check_output("rst.stall_c0", o_stall, 1);
    step();
    check_output("rst.rmask_wait", o_rmask, 8'h0F);
    rst_n = 1'b0;
    #1;
    check_output("rst.outputs", {o_stall, o_ldv, o_rmask, o_wmask, o_addr, o_mis, o_ill}, 0);
    check_output("rst.ld_data", o_ld, 0);
    step();
    rst_n = 1'b1;
    req_valid = 1'b0;
    resp = 1'b1;
    rdata = 64'h5555_5555;
    step();
    resp = 1'b0;
    check_output("rst.stray_resp", {o_ldv, o_stall, o_rmask, o_addr}, 0);
    step();
    check_output("rst.still_idle", {o_ldv, o_stall, o_ld[31:0]}, 0);

    check_output("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
